// File: rtl/id_ex_stage_reg_pkg.sv
// Shared core definitions for the ID/EX pipeline register: widths, the
// control-field bundle that a bubble clears, and the stall counter helper.
package id_ex_stage_reg_pkg;

  localparam int XLEN        = 32;
  localparam int REG_LABEL_W = 5;
  localparam int ALU_OP_W    = 4;
  localparam int STALL_CNT_W = 16;

  typedef logic [REG_LABEL_W-1:0] reg_label_t;
  typedef logic [ALU_OP_W-1:0]    alu_op_t;
  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  // Fields that decide whether the EX slot has any architectural effect.
  // A bubble is exactly this bundle cleared; everything else in ID/EX holds.
  typedef struct packed {
    logic       valid;
    logic       reg_wb_en;
    logic       mem_rd_en;
    logic       mem_wr_en;
    reg_label_t rs1_label;
    reg_label_t rs2_label;
    reg_label_t rd_label;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t BUBBLE_CTRL = '0;

  // Saturating increment: an all-ones count stays all-ones.
  function automatic stall_cnt_t sat_inc(input stall_cnt_t v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detector.sv
// Load-use hazard detection: a valid load in EX whose destination is a
// source actually read by the valid instruction in ID. x0 never hazards,
// and a flush kills the ID instruction so no stall is requested.
module load_use_detector
  import id_ex_stage_reg_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_mem_rd_en_i,
  input  reg_label_t ex_rd_label_i,
  input  logic       id_valid_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  reg_label_t id_rs1_label_i,
  input  reg_label_t id_rs2_label_i,
  input  logic       flush_i,
  output logic       load_use_stall_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1_i && (id_rs1_label_i == ex_rd_label_i);
  assign rs2_hit = id_uses_rs2_i && (id_rs2_label_i == ex_rd_label_i);

  assign load_use_stall_o = ex_valid_i && ex_mem_rd_en_i && (ex_rd_label_i != '0) &&
                            id_valid_i && (rs1_hit || rs2_hit) && !flush_i;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with same-cycle write-back bypass on the source
// operands, bubble insertion for flush / load-use / invalid ID, freeze on
// downstream stall, and a saturating count of load-use bubbles.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int XLEN = id_ex_stage_reg_pkg::XLEN
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                valid_id_i,
  input  logic [XLEN-1:0]     pc_id_i,
  input  logic [XLEN-1:0]     rs1_data_id_i,
  input  logic [XLEN-1:0]     rs2_data_id_i,
  input  logic [XLEN-1:0]     imm_id_i,
  input  logic [4:0]          rs1_label_id_i,
  input  logic [4:0]          rs2_label_id_i,
  input  logic [4:0]          rd_label_id_i,
  input  logic [3:0]          alu_op_id_i,
  input  logic                alu_src_id_i,
  input  logic                mem_rd_en_id_i,
  input  logic                mem_wr_en_id_i,
  input  logic                reg_wb_en_id_i,
  input  logic                uses_rs1_id_i,
  input  logic                uses_rs2_id_i,
  input  logic [4:0]          rd_label_wb_i,
  input  logic                reg_wb_en_wb_i,
  input  logic [XLEN-1:0]     wb_data_i,
  output logic [XLEN-1:0]     pc_id_ex_o,
  output logic [XLEN-1:0]     rs1_data_id_ex_o,
  output logic [XLEN-1:0]     rs2_data_id_ex_o,
  output logic [XLEN-1:0]     imm_id_ex_o,
  output logic [4:0]          rs1_label_id_ex_o,
  output logic [4:0]          rs2_label_id_ex_o,
  output logic [4:0]          rd_label_id_ex_o,
  output logic [3:0]          alu_op_id_ex_o,
  output logic                alu_src_id_ex_o,
  output logic                mem_rd_en_id_ex_o,
  output logic                mem_wr_en_id_ex_o,
  output logic                reg_wb_en_id_ex_o,
  output logic                uses_rs1_id_ex_o,
  output logic                uses_rs2_id_ex_o,
  output logic                valid_id_ex_o,
  output logic                load_use_stall_o,
  output logic [15:0]         stall_cnt_o
);

  // Fields that keep their previous value when a bubble is loaded.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    alu_op_t         alu_op;
    logic            alu_src;
    logic            uses_rs1;
    logic            uses_rs2;
  } payload_t;

  id_ex_ctrl_t ctrl_q, ctrl_d;
  payload_t    data_q, data_d;
  stall_cnt_t  stall_cnt_q, stall_cnt_d;

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            load_use;

  // The register file is written at the end of this cycle, so a matching
  // write-back must be taken from the WB port instead of the stale read.
  assign rs1_fwd = (reg_wb_en_wb_i && (rd_label_wb_i != '0) && (rd_label_wb_i == rs1_label_id_i))
                   ? wb_data_i : rs1_data_id_i;
  assign rs2_fwd = (reg_wb_en_wb_i && (rd_label_wb_i != '0) && (rd_label_wb_i == rs2_label_id_i))
                   ? wb_data_i : rs2_data_id_i;

  load_use_detector u_load_use_detector (
    .ex_valid_i      (ctrl_q.valid),
    .ex_mem_rd_en_i  (ctrl_q.mem_rd_en),
    .ex_rd_label_i   (ctrl_q.rd_label),
    .id_valid_i      (valid_id_i),
    .id_uses_rs1_i   (uses_rs1_id_i),
    .id_uses_rs2_i   (uses_rs2_id_i),
    .id_rs1_label_i  (rs1_label_id_i),
    .id_rs2_label_i  (rs2_label_id_i),
    .flush_i         (flush_i),
    .load_use_stall_o(load_use)
  );

  // Next-state selection: flush beats stall beats load-use beats capture.
  always_comb begin
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      ctrl_d = BUBBLE_CTRL;
    end else if (stall_i) begin
      ctrl_d = ctrl_q;
    end else if (load_use) begin
      ctrl_d      = BUBBLE_CTRL;
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else if (!valid_id_i) begin
      ctrl_d = BUBBLE_CTRL;
    end else begin
      ctrl_d.valid     = 1'b1;
      ctrl_d.reg_wb_en = reg_wb_en_id_i;
      ctrl_d.mem_rd_en = mem_rd_en_id_i;
      ctrl_d.mem_wr_en = mem_wr_en_id_i;
      ctrl_d.rs1_label = rs1_label_id_i;
      ctrl_d.rs2_label = rs2_label_id_i;
      ctrl_d.rd_label  = rd_label_id_i;
      data_d.pc        = pc_id_i;
      data_d.rs1_data  = rs1_fwd;
      data_d.rs2_data  = rs2_fwd;
      data_d.imm       = imm_id_i;
      data_d.alu_op    = alu_op_id_i;
      data_d.alu_src   = alu_src_id_i;
      data_d.uses_rs1  = uses_rs1_id_i;
      data_d.uses_rs2  = uses_rs2_id_i;
    end
  end

  // Stage register; reset leaves a bubble with all fields zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q      <= BUBBLE_CTRL;
      data_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_id_ex_o        = data_q.pc;
  assign rs1_data_id_ex_o  = data_q.rs1_data;
  assign rs2_data_id_ex_o  = data_q.rs2_data;
  assign imm_id_ex_o       = data_q.imm;
  assign alu_op_id_ex_o    = data_q.alu_op;
  assign alu_src_id_ex_o   = data_q.alu_src;
  assign uses_rs1_id_ex_o  = data_q.uses_rs1;
  assign uses_rs2_id_ex_o  = data_q.uses_rs2;
  assign rs1_label_id_ex_o = ctrl_q.rs1_label;
  assign rs2_label_id_ex_o = ctrl_q.rs2_label;
  assign rd_label_id_ex_o  = ctrl_q.rd_label;
  assign mem_rd_en_id_ex_o = ctrl_q.mem_rd_en;
  assign mem_wr_en_id_ex_o = ctrl_q.mem_wr_en;
  assign reg_wb_en_id_ex_o = ctrl_q.reg_wb_en;
  assign valid_id_ex_o     = ctrl_q.valid;
  assign load_use_stall_o  = load_use;
  assign stall_cnt_o       = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed hazard/bypass/flush/
// stall/reset scenarios followed by randomized traffic, all compared against
// a behavioural model of the ID/EX slot.
module tb_id_ex_stage_reg;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, valid_id_i;
  logic [31:0] pc_id_i, rs1_data_id_i, rs2_data_id_i, imm_id_i;
  logic [4:0]  rs1_label_id_i, rs2_label_id_i, rd_label_id_i;
  logic [3:0]  alu_op_id_i;
  logic        alu_src_id_i, mem_rd_en_id_i, mem_wr_en_id_i, reg_wb_en_id_i;
  logic        uses_rs1_id_i, uses_rs2_id_i;
  logic [4:0]  rd_label_wb_i;
  logic        reg_wb_en_wb_i;
  logic [31:0] wb_data_i;

  logic [31:0] pc_o, rs1d_o, rs2d_o, imm_o;
  logic [4:0]  rs1l_o, rs2l_o, rdl_o;
  logic [3:0]  aluop_o;
  logic        alusrc_o, memrd_o, memwr_o, wben_o, u1_o, u2_o, valid_o, lu_o;
  logic [15:0] cnt_o;

  id_ex_stage_reg #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_id_i(valid_id_i), .pc_id_i(pc_id_i), .rs1_data_id_i(rs1_data_id_i),
    .rs2_data_id_i(rs2_data_id_i), .imm_id_i(imm_id_i),
    .rs1_label_id_i(rs1_label_id_i), .rs2_label_id_i(rs2_label_id_i),
    .rd_label_id_i(rd_label_id_i), .alu_op_id_i(alu_op_id_i),
    .alu_src_id_i(alu_src_id_i), .mem_rd_en_id_i(mem_rd_en_id_i),
    .mem_wr_en_id_i(mem_wr_en_id_i), .reg_wb_en_id_i(reg_wb_en_id_i),
    .uses_rs1_id_i(uses_rs1_id_i), .uses_rs2_id_i(uses_rs2_id_i),
    .rd_label_wb_i(rd_label_wb_i), .reg_wb_en_wb_i(reg_wb_en_wb_i),
    .wb_data_i(wb_data_i),
    .pc_id_ex_o(pc_o), .rs1_data_id_ex_o(rs1d_o), .rs2_data_id_ex_o(rs2d_o),
    .imm_id_ex_o(imm_o), .rs1_label_id_ex_o(rs1l_o), .rs2_label_id_ex_o(rs2l_o),
    .rd_label_id_ex_o(rdl_o), .alu_op_id_ex_o(aluop_o), .alu_src_id_ex_o(alusrc_o),
    .mem_rd_en_id_ex_o(memrd_o), .mem_wr_en_id_ex_o(memwr_o),
    .reg_wb_en_id_ex_o(wben_o), .uses_rs1_id_ex_o(u1_o), .uses_rs2_id_ex_o(u2_o),
    .valid_id_ex_o(valid_o), .load_use_stall_o(lu_o), .stall_cnt_o(cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Behavioural view of the EX slot.
  bit          m_valid, m_wb, m_memrd, m_memwr, m_alusrc, m_u1, m_u2;
  bit [31:0]   m_pc, m_rs1, m_rs2, m_imm;
  bit [4:0]    m_rs1l, m_rs2l, m_rd;
  bit [3:0]    m_aluop;
  bit [15:0]   m_cnt;

  function automatic void model_reset();
    m_valid = 0; m_wb = 0; m_memrd = 0; m_memwr = 0; m_alusrc = 0; m_u1 = 0; m_u2 = 0;
    m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rs1l = 0; m_rs2l = 0; m_rd = 0;
    m_aluop = 0; m_cnt = 0;
  endfunction

  function automatic void model_bubble();
    m_valid = 0; m_wb = 0; m_memrd = 0; m_memwr = 0; m_rs1l = 0; m_rs2l = 0; m_rd = 0;
  endfunction

  // Value the ID stage should see for a source register this cycle.
  function automatic bit [31:0] operand(input bit [4:0] lbl, input bit [31:0] rf);
    if (reg_wb_en_wb_i && rd_label_wb_i != 0 && rd_label_wb_i == lbl) return wb_data_i;
    return rf;
  endfunction

  function automatic bit model_hazard();
    bit reads_load;
    reads_load = (uses_rs1_id_i && rs1_label_id_i == m_rd) ||
                 (uses_rs2_id_i && rs2_label_id_i == m_rd);
    return m_valid && m_memrd && (m_rd != 0) && valid_id_i && reads_load && !flush_i;
  endfunction

  function automatic void model_edge();
    bit hz;
    hz = model_hazard();
    if (flush_i) model_bubble();
    else if (stall_i) begin end
    else if (hz) begin
      model_bubble();
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (!valid_id_i) model_bubble();
    else begin
      m_valid = 1; m_wb = reg_wb_en_id_i; m_memrd = mem_rd_en_id_i; m_memwr = mem_wr_en_id_i;
      m_rs1l = rs1_label_id_i; m_rs2l = rs2_label_id_i; m_rd = rd_label_id_i;
      m_pc = pc_id_i; m_imm = imm_id_i; m_aluop = alu_op_id_i; m_alusrc = alu_src_id_i;
      m_u1 = uses_rs1_id_i; m_u2 = uses_rs2_id_i;
      m_rs1 = operand(rs1_label_id_i, rs1_data_id_i);
      m_rs2 = operand(rs2_label_id_i, rs2_data_id_i);
    end
  endfunction

  task automatic check_outputs();
    chk("valid", valid_o, m_valid);   chk("pc", pc_o, m_pc);
    chk("rs1_data", rs1d_o, m_rs1);   chk("rs2_data", rs2d_o, m_rs2);
    chk("imm", imm_o, m_imm);         chk("rs1_label", rs1l_o, m_rs1l);
    chk("rs2_label", rs2l_o, m_rs2l); chk("rd_label", rdl_o, m_rd);
    chk("alu_op", aluop_o, m_aluop);  chk("alu_src", alusrc_o, m_alusrc);
    chk("mem_rd_en", memrd_o, m_memrd); chk("mem_wr_en", memwr_o, m_memwr);
    chk("reg_wb_en", wben_o, m_wb);   chk("uses_rs1", u1_o, m_u1);
    chk("uses_rs2", u2_o, m_u2);      chk("stall_cnt", cnt_o, m_cnt);
  endtask

  // Inputs are already driven (posedge+1); check the combinational stall,
  // advance the model across the edge, then check the registered state.
  task automatic step();
    #1;
    chk("load_use_stall", lu_o, model_hazard());
    model_edge();
    @(posedge clk_i); #1;
    check_outputs();
  endtask

  task automatic set_id(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] rd,
                        input bit u1, input bit u2, input bit ld, input bit wb);
    valid_id_i = v; rs1_label_id_i = r1; rs2_label_id_i = r2; rd_label_id_i = rd;
    uses_rs1_id_i = u1; uses_rs2_id_i = u2; mem_rd_en_id_i = ld; reg_wb_en_id_i = wb;
    mem_wr_en_id_i = 0; alu_src_id_i = $urandom_range(0, 1); alu_op_id_i = 4'($urandom);
    pc_id_i = $urandom; rs1_data_id_i = $urandom; rs2_data_id_i = $urandom; imm_id_i = $urandom;
  endtask

  task automatic quiet_ctl();
    stall_i = 0; flush_i = 0; reg_wb_en_wb_i = 0; rd_label_wb_i = 0; wb_data_i = 0;
  endtask

  bit [31:0] held_pc;

  initial begin
    rst_i = 1;
    quiet_ctl();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs();
    chk("reset_lu", lu_o, 0);
    rst_i = 0;

    // Load-use on rs1: one bubble, counter to 1, then the add is captured.
    set_id(1, 1, 2, 5, 1, 1, 1, 1); step();
    set_id(1, 5, 3, 6, 1, 1, 0, 1);
    #1 chk("ldu_rs1_stall", lu_o, 1);
    step();
    chk("ldu_bubble_valid", valid_o, 0); chk("ldu_cnt_1", cnt_o, 1);
    step();
    chk("ldu_add_captured", valid_o, 1); chk("ldu_add_rd", rdl_o, 6);

    // rs2 matches but is not read; load to x0 read through rs1=x0.
    set_id(1, 1, 2, 5, 1, 1, 1, 1); step();
    set_id(1, 1, 5, 6, 0, 0, 0, 1);
    #1 chk("unused_rs2_no_stall", lu_o, 0);
    step();
    set_id(1, 1, 2, 0, 1, 1, 1, 1); step();
    set_id(1, 0, 0, 6, 1, 1, 0, 1);
    #1 chk("x0_no_stall", lu_o, 0);
    step();

    // Write-back bypass of x7 into rs2.
    set_id(1, 3, 7, 8, 1, 1, 0, 1);
    rs2_data_id_i = 32'h0; reg_wb_en_wb_i = 1; rd_label_wb_i = 7; wb_data_i = 32'hDEADBEEF;
    step();
    chk("bypass_rs2", rs2d_o, 32'hDEADBEEF);
    quiet_ctl();

    // Flush wins over stall and over a pending load-use hazard.
    set_id(1, 1, 2, 5, 1, 1, 1, 1); step();
    set_id(1, 5, 5, 6, 1, 1, 0, 1); flush_i = 1; stall_i = 1;
    #1 chk("flush_lu", lu_o, 0);
    step();
    chk("flush_valid", valid_o, 0); chk("flush_cnt", cnt_o, 1);
    quiet_ctl();

    // Three stalled cycles hold the captured instruction.
    set_id(1, 9, 10, 11, 1, 1, 0, 1); held_pc = pc_id_i; step();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin set_id(1, 12, 13, 14, 1, 1, 1, 1); step(); end
    chk("stall_pc_held", pc_o, held_pc); chk("stall_rd_held", rdl_o, 11);
    quiet_ctl();

    // Counter saturation: preset to all-ones, then take a hazard.
    set_id(1, 1, 2, 5, 1, 1, 1, 1); step();
    force dut.stall_cnt_q = 16'hFFFF;
    #1 release dut.stall_cnt_q;
    m_cnt = 16'hFFFF;
    chk("cnt_preset", cnt_o, 16'hFFFF);
    set_id(1, 5, 2, 6, 1, 0, 0, 1);
    step();
    chk("cnt_saturated", cnt_o, 16'hFFFF); chk("sat_bubble", valid_o, 0);

    // Asynchronous reset while a stalled instruction is held.
    set_id(1, 4, 4, 9, 1, 1, 0, 1); step();
    stall_i = 1;
    #1 rst_i = 1;
    #1 chk("async_rst_valid", valid_o, 0); chk("async_rst_pc", pc_o, 0);
    chk("async_rst_rd", rdl_o, 0); chk("async_rst_cnt", cnt_o, 0);
    model_reset();
    #1 rst_i = 0;
    step();
    quiet_ctl();

    // Randomized traffic on a small label set to provoke hazards and bypasses.
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1));
      mem_wr_en_id_i = $urandom_range(0, 1);
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      reg_wb_en_wb_i = $urandom_range(0, 1);
      rd_label_wb_i = 5'($urandom_range(0, 3));
      wb_data_i = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
